// File: rtl/sp_mem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for a single-port memory.
// Requests are serialised onto one memory port; each access ends with a one-cycle
// ready pulse to the granted requester. A watchdog aborts unacknowledged accesses.
module sp_mem_arbiter #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned ADDR_SIZE   = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   req0_valid,
  input  logic                   req0_wr_rd,
  input  logic [ADDR_SIZE-1:0]   req0_addr,
  input  logic [DATA_LENGTH-1:0] req0_wdata,
  output logic                   req0_ready,
  output logic                   req0_err,
  output logic [DATA_LENGTH-1:0] req0_rdata,

  input  logic                   req1_valid,
  input  logic                   req1_wr_rd,
  input  logic [ADDR_SIZE-1:0]   req1_addr,
  input  logic [DATA_LENGTH-1:0] req1_wdata,
  output logic                   req1_ready,
  output logic                   req1_err,
  output logic [DATA_LENGTH-1:0] req1_rdata,

  output logic                   mem_valid,
  output logic                   mem_wr_rd,
  output logic [ADDR_SIZE-1:0]   mem_addr,
  output logic [DATA_LENGTH-1:0] mem_wdata,
  input  logic [DATA_LENGTH-1:0] mem_rdata,
  input  logic                   mem_ready
);

  // Wait counter only needs to reach TIMEOUT-1 (TIMEOUT >= 2, so CntW >= 1).
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e                 state_q;
  logic                   prio_q;
  logic                   gnt_q;
  logic [CntW-1:0]        cnt_q;
  logic                   err_q;
  logic [DATA_LENGTH-1:0] rdata_q;
  logic [1:0]             ready_q;

  // Command register doubles as the memory-side outputs, so they never glitch.
  logic                   mem_valid_q;
  logic                   mem_wr_rd_q;
  logic [ADDR_SIZE-1:0]   mem_addr_q;
  logic [DATA_LENGTH-1:0] mem_wdata_q;

  logic any_req;
  logic pick;

  // Arbitration: a lone requester wins; under contention the prio holder wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    pick    = 1'b0;
    if (req0_valid && req1_valid) begin
      pick = prio_q;
    end else if (req1_valid) begin
      pick = 1'b1;
    end
  end

  // Main sequencer: grant, hold the memory port, then pulse completion once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 2'b00;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q     <= StBusy;
            gnt_q       <= pick;
            prio_q      <= ~pick;
            cnt_q       <= '0;
            mem_valid_q <= 1'b1;
            mem_wr_rd_q <= pick ? req1_wr_rd : req0_wr_rd;
            mem_addr_q  <= pick ? req1_addr  : req0_addr;
            mem_wdata_q <= pick ? req1_wdata : req0_wdata;
          end
        end

        StBusy: begin
          if (mem_ready) begin
            state_q     <= StDone;
            mem_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= gnt_q ? 2'b10 : 2'b01;
            if (!mem_wr_rd_q) begin
              rdata_q <= mem_rdata;
            end
          end else if (cnt_q == CntLast) begin
            // Watchdog expiry: report an error and clear stale read data.
            state_q     <= StDone;
            mem_valid_q <= 1'b0;
            err_q       <= 1'b1;
            rdata_q     <= '0;
            ready_q     <= gnt_q ? 2'b10 : 2'b01;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StDone: begin
          state_q <= StIdle;
          ready_q <= 2'b00;
        end

        default: begin
          state_q     <= StIdle;
          ready_q     <= 2'b00;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping; all terms come straight from registers.
  always_comb begin
    req0_ready = ready_q[0];
    req1_ready = ready_q[1];
    req0_err   = ready_q[0] & err_q;
    req1_err   = ready_q[1] & err_q;
    req0_rdata = rdata_q;
    req1_rdata = rdata_q;
    mem_valid  = mem_valid_q;
    mem_wr_rd  = mem_wr_rd_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
  end

  // Structural invariants of the sequencer.
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst)
    !(ready_q[0] && ready_q[1]));
  a_valid_in_busy : assert property (@(posedge clk) disable iff (!rst)
    mem_valid_q |-> (state_q == StBusy));
  a_ready_in_done : assert property (@(posedge clk) disable iff (!rst)
    (ready_q != 2'b00) |-> (state_q == StDone));

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Self-checking bench for sp_mem_arbiter: behavioural memory with programmable wait
// states, reference memory and a queue of expected accesses/completions.
module tb_sp_mem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 0, req0_wr_rd = 0, req1_valid = 0, req1_wr_rd = 0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          req0_ready, req0_err, req1_ready, req1_err;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          mem_valid, mem_wr_rd, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sp_mem_arbiter #(.DATA_LENGTH(DW), .ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_wr_rd(req0_wr_rd), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_err(req0_err),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_wr_rd(req1_wr_rd), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_err(req1_err),
    .req1_rdata(req1_rdata),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Behavioural memory: acknowledges after wait_n wait cycles unless mem_dead.
  logic [DW-1:0] mem_model [16];
  int unsigned   wait_n = 0;
  bit            mem_dead = 0;
  bit            rnd_rdy = 0;
  logic [DW-1:0] rnd_rdata = '0;
  int unsigned   run_len = 0;
  int unsigned   last_len = 0;
  int unsigned   ready_cnt = 0;

  assign mem_ready = (mem_valid && !mem_dead && (run_len > wait_n)) || rnd_rdy;
  assign mem_rdata = mem_model[mem_addr] ^ rnd_rdata;

  always @(posedge clk) begin
    if (rst && mem_valid && mem_ready && mem_wr_rd) mem_model[mem_addr] <= mem_wdata;
  end

  typedef struct {
    bit            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] last_rdata = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outcome is derived from the bench's own reference memory.
  task automatic push_exp(input bit port, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input bit err);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.wdata = data; e.err = err;
    if (err) begin
      last_rdata = '0;
    end else if (wr) begin
      ref_mem[addr] = data;
    end else begin
      last_rdata = ref_mem[addr];
    end
    e.rdata = last_rdata;
    sb.push_back(e);
  endtask

  // Monitor: checks access start against the queue head, completions against a pop.
  always @(negedge clk) begin
    exp_t e;
    if (mem_valid) begin
      if (run_len == 0) begin
        if (sb.size() == 0) begin
          check_eq("unexp_access", mem_valid, 0);
        end else begin
          e = sb[0];
          check_eq("acc_wr", mem_wr_rd, e.wr);
          check_eq("acc_addr", mem_addr, e.addr);
          if (e.wr) check_eq("acc_wdata", mem_wdata, e.wdata);
        end
      end
      run_len <= run_len + 1;
    end else begin
      if (run_len != 0) last_len <= run_len;
      run_len <= 0;
    end
    if (req0_ready || req1_ready) begin
      ready_cnt <= ready_cnt + 1;
      check_eq("ready_excl", req0_ready & req1_ready, 0);
      if (sb.size() == 0) begin
        check_eq("unexp_ready", {req1_ready, req0_ready}, 0);
      end else begin
        e = sb.pop_front();
        check_eq("ready_port", {req1_ready, req0_ready}, e.port ? 2'b10 : 2'b01);
        check_eq("ready_err", e.port ? req1_err : req0_err, e.err);
        check_eq("rdata0", req0_rdata, e.rdata);
        check_eq("rdata1", req1_rdata, e.rdata);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input bit v, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (port) begin
      req1_valid = v; req1_wr_rd = wr; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_wr_rd = wr; req0_addr = a; req0_wdata = d;
    end
  endtask

  task automatic issue(input bit port, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit err);
    bit ok = 0;
    push_exp(port, wr, a, d, err);
    set_req(port, 1, wr, a, d);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (port ? req1_ready : req0_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("issue_wait", port ? req1_ready : req0_ready, 1);
    tick();
    set_req(port, 0, 0, '0, '0);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check_eq(tag, sb.size(), 0);
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_mem"}, {mem_valid, mem_wr_rd, mem_addr, mem_wdata}, 0);
    check_eq({tag, "_req"}, {req0_ready, req0_err, req1_ready, req1_err, req0_rdata}, 0);
    check_eq({tag, "_rd1"}, req1_rdata, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned rc;
    bit seen;
    // Reset with random inputs: every output must be zero.
    #2 rst = 0;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'($urandom); req0_wr_rd = 1'($urandom);
      req0_addr = 4'($urandom); req0_wdata = $urandom;
      req1_valid = 1'($urandom); req1_wr_rd = 1'($urandom);
      req1_addr = 4'($urandom); req1_wdata = $urandom;
      rnd_rdy = 1'($urandom); rnd_rdata = $urandom;
      tick();
      check_outs_zero("rst");
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    rnd_rdy = 0; rnd_rdata = '0;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_no_valid", mem_valid, 0);
    end

    // Write then read on req0 with two wait cycles.
    wait_n = 2;
    issue(0, 1, 4'd3, 32'hDEADBEEF, 0);
    check_eq("wr_valid_len", last_len, 3);
    issue(0, 0, 4'd3, '0, 0);
    check_eq("rd_valid_len", last_len, 3);

    // Contention from reset: strict alternation 0,1,0,1.
    wait_n = 0;
    rst = 0;
    last_rdata = '0;
    tick();
    for (int i = 0; i < 2; i++) begin
      push_exp(0, 1, 4'd0, 32'hA5A50000, 0);
      push_exp(1, 1, 4'd15, 32'h5A5A000F, 0);
    end
    set_req(0, 1, 1, 4'd0, 32'hA5A50000);
    set_req(1, 1, 1, 4'd15, 32'h5A5A000F);
    tick();
    rst = 1;
    wait_drain("contention_drain");
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    tick();

    // Priority memory: req1 alone, then contention goes to req0.
    issue(1, 1, 4'd9, 32'h99990009, 0);
    push_exp(0, 0, 4'd15, '0, 0);
    push_exp(1, 0, 4'd0, '0, 0);
    set_req(0, 1, 0, 4'd15, '0);
    set_req(1, 1, 0, 4'd0, '0);
    wait_drain("prio_drain");
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    tick();

    // Watchdog expiry on a req1 read, then a normal access.
    mem_dead = 1;
    issue(1, 0, 4'd5, '0, 1);
    check_eq("timeout_len", last_len, TO);
    mem_dead = 0;
    issue(1, 0, 4'd3, '0, 0);

    // Reset two cycles after a grant aborts the access without a ready pulse.
    wait_n = 20;
    push_exp(0, 0, 4'd3, '0, 0);
    set_req(0, 1, 0, 4'd3, '0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_valid) begin
        seen = 1;
        break;
      end
    end
    check_eq("abort_grant", seen, 1);
    tick();
    tick();
    rc = ready_cnt;
    rst = 0;
    #1;
    check_eq("abort_async", mem_valid, 0);
    set_req(0, 0, 0, '0, '0);
    sb.delete();
    last_rdata = '0;
    tick();
    tick();
    check_eq("abort_no_ready", ready_cnt, rc);
    check_outs_zero("abort");
    // Fresh contention after reset: prio is back to 0, so req0 goes first.
    wait_n = 0;
    push_exp(0, 0, 4'd3, '0, 0);
    push_exp(1, 1, 4'd1, 32'h01234567, 0);
    set_req(0, 1, 0, 4'd3, '0);
    set_req(1, 1, 1, 4'd1, 32'h01234567);
    rst = 1;
    wait_drain("post_abort_drain");
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_mem_arbiter.md
# sp_mem_arbiter

Two-requester round-robin arbiter and access sequencer for the single-port memory `sp_memory`. It accepts read/write requests from two independent masters over a valid/ready handshake. It serialises them onto the memory's single `valid`/`wr_rd`/`addr`/`wdata` port and returns read data with a one-cycle completion pulse. A watchdog aborts any access the memory fails to acknowledge within `TIMEOUT` cycles.

## Interface
- `DATA_LENGTH`, 32, data width of memory and requesters
- `ADDR_SIZE`, 4, address width (memory depth 2**ADDR_SIZE)
- `TIMEOUT`, 16, max cycles `mem_valid` is held awaiting `mem_ready`; legal range 2..256

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `reqN_valid` in 1 (N=0,1): request present; fields below stable while high
- `reqN_wr_rd` in 1: 1 = write, 0 = read
- `reqN_addr` in ADDR_SIZE: target address
- `reqN_wdata` in DATA_LENGTH: write data
- `reqN_ready` out 1: one-cycle completion pulse for requester N
- `reqN_err` out 1: high with `reqN_ready` when access timed out
- `reqN_rdata` out DATA_LENGTH: read data; valid only while `reqN_ready`=1 and `reqN_err`=0 for a read
- `mem_valid` out 1, `mem_wr_rd` out 1, `mem_addr` out ADDR_SIZE, `mem_wdata` out DATA_LENGTH: to memory
- `mem_rdata` in DATA_LENGTH, `mem_ready` in 1: from memory; read data valid in the cycle `mem_ready`=1

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if either `reqN_valid` is high at the edge, grant one requester and go to BUSY. Latch its `wr_rd`/`addr`/`wdata` into a command register, record `gnt` = N, clear `cnt`.
- Arbitration: `prio` register (reset 0). Only one valid → that one wins. Both valid → requester `prio` wins. On every grant, `prio` <= the non-granted index, i.e. strict alternation under continuous contention.
- BUSY: `mem_valid`=1, `mem_*` driven from the command register (registered, glitch-free).
  - If `mem_ready`=1 at the edge → DONE, `err_q`=0. On a read, `rdata_q` <= `mem_rdata`.
  - Else if `cnt`==TIMEOUT-1 → DONE, `err_q`=1, `rdata_q` <= 0.
  - Else `cnt`++.
- DONE: `req[gnt]_ready`=1 and `req[gnt]_err`=`err_q` for exactly one cycle, then → IDLE unconditionally. `mem_valid`=0.
- The handshake completes at the edge ending DONE. The requester drops `valid` or presents its next request after that edge. `reqN_valid` is ignored in BUSY and DONE.
- `reqN_rdata` = `rdata_q` for both ports. It changes only on read completion or timeout; write completions leave it unchanged.
- Address is passed through unchanged; no wrap logic (0..2**ADDR_SIZE-1 all legal).
- Deassertion of `reqN_valid` during BUSY does not cancel the access; it completes and pulses `ready`.

## Timing
- Reset values: state IDLE, `prio`=0, `gnt`=0, `cnt`=0, `rdata_q`=0, `err_q`=0. All outputs 0 (`mem_valid`, `mem_wr_rd`, `mem_addr`, `mem_wdata`, `reqN_ready`, `reqN_err`, `reqN_rdata`).
- Reset assertion mid-access clears everything immediately (asynchronous). `mem_valid` falls without waiting for a clock, and no `ready` pulse is issued for the aborted access.
- Latency, zero-wait memory (`mem_ready` high while `mem_valid` high): valid sampled at edge k, `mem_valid` high in cycle k..k+1, `ready` high in cycle k+1..k+2. Back-to-back throughput is one access per 3 cycles.
- W wait cycles add W to latency. `mem_valid` is high for at most TIMEOUT cycles.
- `mem_ready` outside BUSY is ignored.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0. Release → IDLE, no `mem_valid` until a `valid` is seen.
- Write then read, req0, memory ready after 2 waits: write addr 3 data 32'hDEADBEEF → `mem_valid` high 3 cycles with `mem_wr_rd`=1, `mem_addr`=3, then `req0_ready` pulse, `req0_err`=0. Read addr 3 → `req0_rdata`=32'hDEADBEEF during `req0_ready`.
- Contention: both valid continuously from reset, req0 writing addr 0, req1 writing addr 15 → grant order 0,1,0,1. `req1_ready` never asserted in the same cycle as `req0_ready`. `mem_addr` alternates 0,15.
- Priority memory: req1 alone once, then both valid → req0 granted next.
- Timeout: `mem_ready` tied 0, req1 read → `mem_valid` high exactly 16 cycles, then `req1_ready`=1, `req1_err`=1, `req1_rdata`=0. A following access with `mem_ready`=1 completes with `err`=0.
- Reset mid-BUSY: assert `rst` low 2 cycles after grant → `mem_valid` drops asynchronously, no `ready` pulse. After release, a fresh req0 request completes normally with `prio`=0 behaviour.
